// File: rtl/branch_resolve_queue.sv
// In-order queue of branch predictions awaiting resolution by execute.
// Resolving the head drives the predictor update, flags mispredicts and flushes younger entries.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid,
  input  logic             pred_taken,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             upd_valid,
  output logic             upd_taken,
  output logic             mispredict,
  output logic             err_underflow,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t             state, state_nxt;
  logic [DEPTH-1:0]   entries;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [OCC_W-1:0]   occ;
  logic               push, pop, miss;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign empty = (occ == '0);
  assign full  = (occ == OCC_W'(DEPTH));
  assign push  = pred_valid && pred_ready;
  assign pop   = res_valid && !empty && (state == RUN);
  assign miss  = pop && (entries[rd_ptr] != res_taken);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (miss) state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pred_ready = (state == RUN) && !full;
  end

  // Storage holds only data; its contents are meaningless until pointers cover them.
  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= pred_taken;
  end

  // Pointer/occupancy update; a mispredict drops everything younger than the head, including a same-cycle push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (miss) begin
      rd_ptr <= rd_ptr + PTR_W'(1);
      wr_ptr <= rd_ptr + PTR_W'(1);
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Registered resolution outputs, valid the cycle after the resolving edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_valid        <= 1'b0;
      upd_taken        <= 1'b0;
      mispredict       <= 1'b0;
      err_underflow    <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      upd_valid     <= pop;
      upd_taken     <= pop && res_taken;
      mispredict    <= miss;
      err_underflow <= res_valid && !pop;
      if (pop)  branch_count     <= sat_inc(branch_count);
      if (miss) mispredict_count <= sat_inc(mispredict_count);
    end
  end

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Tracks in-flight branch predictions between the 2-bit saturating-counter predictor and the execute stage's branch resolution. Each prediction the predictor issues is enqueued in program order. When execute resolves the oldest branch, the block compares outcome against prediction, then drives the predictor's update strobe and outcome. It also raises a one-cycle mispredict/flush that discards all younger wrong-path entries, and keeps branch and mispredict statistics.

## Interface
- DEPTH, 4, queue entries (power of two, >= 2)
- CNT_W, 16, width of statistics counters
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- pred_valid  in  1  predictor issued a prediction this cycle
- pred_taken  in  1  predicted direction (predictor `prediction`)
- pred_ready  out  1  queue accepts a push this cycle
- res_valid  in  1  execute resolved the oldest branch
- res_taken  in  1  actual direction
- upd_valid  out  1  update strobe to predictor (drives its `result`)
- upd_taken  out  1  actual direction to predictor (drives its `taken`)
- mispredict  out  1  one-cycle pulse: head prediction was wrong, flush fetch
- err_underflow  out  1  one-cycle pulse: resolve arrived with no entry to match
- empty  out  1  occupancy == 0
- full  out  1  occupancy == DEPTH
- branch_count  out  CNT_W  total resolved branches
- mispredict_count  out  CNT_W  total mispredicted branches

## Operation
- Storage: DEPTH x 1-bit circular buffer, wr_ptr/rd_ptr of log2(DEPTH) bits wrapping modulo DEPTH, occupancy counter 0..DEPTH.
- FSM states RUN, FLUSH. Reset -> RUN.
- pred_ready = (state == RUN) && !full; combinational from registered state.
- Push: pred_valid && pred_ready -> store pred_taken at wr_ptr, wr_ptr+1. pred_valid while !pred_ready is dropped; the upstream holds it.
- Resolve, when res_valid && !empty && state == RUN:
  - pop the head; next cycle upd_valid=1 and upd_taken=res_taken.
  - branch_count+1.
  - if head != res_taken: next cycle mispredict=1, mispredict_count+1, wr_ptr<=rd_ptr+1, occupancy<=0, state->FLUSH.
- Resolve with empty queue, or in FLUSH: err_underflow=1 next cycle; no update, no counter change.
- FLUSH lasts exactly one cycle: pred_ready=0, then -> RUN.
- Simultaneous push+pop, correct prediction: both performed, occupancy unchanged.
- Simultaneous push+pop, mispredict: push discarded as wrong-path.
- Full: push blocked even if a pop occurs that cycle (pred_ready is state-based).
- Statistics counters saturate at all-ones, no wrap.
- Reset, including mid-flight: pointers, occupancy, counters = 0, queued entries lost, state RUN.

## Timing
- Reset values: upd_valid=0, upd_taken=0, mispredict=0, err_underflow=0, branch_count=0, mispredict_count=0, empty=1, full=0, pred_ready=1.
- upd_valid, upd_taken, mispredict, err_underflow are registered: asserted the cycle after the resolving edge, high one cycle only.
- Back-to-back resolves give back-to-back upd_valid pulses; throughput 1 resolve/cycle.
- empty/full reflect registered occupancy, so they update the cycle after a push/pop.
- Push-to-resolvable latency: an entry pushed at edge N is resolvable at edge N+1.
- After a mispredict resolve at edge N: mispredict high in cycle N+1 (state FLUSH, pred_ready=0); pred_ready returns in cycle N+2.

## Test plan
- Reset, then push 1,0,1; resolve 1,0,1 -> three upd_valid pulses with upd_taken 1,0,1; mispredict never asserted; branch_count=3, mispredict_count=0; empty=1 at end.
- Fill with DEPTH=4 pushes -> full=1, pred_ready=0; 5th push is not stored; resolve one -> full=0 next cycle, pred_ready=1.
- Push 1,1,1; resolve 0 -> upd_taken=0, mispredict pulse, mispredict_count=1, empty=1, pred_ready=0 for one cycle, then 1; further resolve -> err_underflow.
- Push 0 and resolve 0 in the same cycle with 2 entries queued -> occupancy stays 2; with the head mismatching instead -> the pushed entry is discarded and occupancy is 0.
- Exercise pointer wrap-around: 10 push/resolve pairs interleaved with occupancy 3 -> order preserved, no spurious mispredict.
- With 3 entries queued, assert rst_n=0 for one edge -> all outputs at reset values, empty=1; CNT_W=2 with 5 mispredicts -> mispredict_count saturates at 3.
